// File: rtl/vga_csc_pkg.sv
// Shared types and constants for the analogue video colour-space output stage:
// mode encodings, per-channel matrix coefficients and blank levels.
package vga_csc_pkg;

    typedef enum logic [1:0] {
        MODE_RGB   = 2'd0,
        MODE_YPBPR = 2'd1,
        MODE_YCBCR = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        CH_Y = 2'd0,
        CH_B = 2'd1,
        CH_R = 2'd2
    } chan_e;

    // One row of the conversion matrix; off is added in units of 256.
    typedef struct packed {
        logic signed [8:0] c0;
        logic signed [8:0] c1;
        logic signed [8:0] c2;
        logic [7:0]        off;
    } coef_t;

    localparam int LATENCY = 3;
    localparam logic signed [17:0] ROUND_BIAS = 18'sd128;

    localparam coef_t COEF_NONE = '{c0: 9'sd0,   c1: 9'sd0,    c2: 9'sd0,   off: 8'd0};

    localparam coef_t YPBPR_Y   = '{c0: 9'sd77,  c1: 9'sd150,  c2: 9'sd29,  off: 8'd0};
    localparam coef_t YPBPR_PB  = '{c0: -9'sd43, c1: -9'sd85,  c2: 9'sd128, off: 8'd128};
    localparam coef_t YPBPR_PR  = '{c0: 9'sd128, c1: -9'sd107, c2: -9'sd21, off: 8'd128};

    localparam coef_t YCBCR_Y   = '{c0: 9'sd66,  c1: 9'sd129,  c2: 9'sd25,  off: 8'd16};
    localparam coef_t YCBCR_CB  = '{c0: -9'sd38, c1: -9'sd74,  c2: 9'sd112, off: 8'd128};
    localparam coef_t YCBCR_CR  = '{c0: 9'sd112, c1: -9'sd94,  c2: -9'sd18, off: 8'd128};

    localparam logic [7:0] YPBPR_BLANK_Y = 8'd0;
    localparam logic [7:0] YPBPR_BLANK_C = 8'd128;
    localparam logic [7:0] YCBCR_BLANK_Y = 8'd16;
    localparam logic [7:0] YCBCR_BLANK_C = 8'd128;

    // The reserved encoding behaves exactly like RGB.
    function automatic mode_e pixel_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_YPBPR;
            2'd2:    return MODE_YCBCR;
            default: return MODE_RGB;
        endcase
    endfunction

    function automatic coef_t csc_coef(input mode_e m, input chan_e ch);
        coef_t c;
        c = COEF_NONE;
        if (m == MODE_YPBPR) begin
            case (ch)
                CH_Y:    c = YPBPR_Y;
                CH_B:    c = YPBPR_PB;
                default: c = YPBPR_PR;
            endcase
        end else if (m == MODE_YCBCR) begin
            case (ch)
                CH_Y:    c = YCBCR_Y;
                CH_B:    c = YCBCR_CB;
                default: c = YCBCR_CR;
            endcase
        end
        return c;
    endfunction

    function automatic logic [7:0] blank_level(input mode_e m, input chan_e ch);
        logic [7:0] v;
        v = 8'd0;
        if (m == MODE_YPBPR)
            v = (ch == CH_Y) ? YPBPR_BLANK_Y : YPBPR_BLANK_C;
        else if (m == MODE_YCBCR)
            v = (ch == CH_Y) ? YCBCR_BLANK_Y : YCBCR_BLANK_C;
        return v;
    endfunction

endpackage

// File: rtl/vga_csc_channel.sv
// One output channel of the colour matrix: products registered in the first
// stage, rounded sum in the second, clamp to 0..255 on the way out.
module vga_csc_channel
    import vga_csc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    input  coef_t      coef,
    output logic [7:0] result
);

    logic signed [17:0] prod_r;
    logic signed [17:0] prod_g;
    logic signed [17:0] prod_b;
    logic signed [17:0] off_term;
    logic signed [17:0] sum;
    logic signed [9:0]  scaled;

    function automatic logic signed [17:0] mul(input logic signed [8:0] c, input logic [7:0] x);
        logic signed [17:0] cs;
        logic signed [17:0] xs;
        cs = {{9{c[8]}}, c};
        xs = $signed({10'd0, x});
        return cs * xs;
    endfunction

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prod_r   <= '0;
            prod_g   <= '0;
            prod_b   <= '0;
            off_term <= '0;
            sum      <= '0;
        end else begin
            prod_r   <= mul(coef.c0, r);
            prod_g   <= mul(coef.c1, g);
            prod_b   <= mul(coef.c2, b);
            off_term <= $signed({2'b00, coef.off, 8'd0});
            sum      <= off_term + prod_r + prod_g + prod_b + ROUND_BIAS;
        end
    end

    // Arithmetic shift by 8; the sum always fits the 10 remaining bits.
    assign scaled = sum[17:8];

    always_comb begin
        result = scaled[7:0];
        if (scaled < 10'sd0)
            result = 8'd0;
        else if (scaled > 10'sd255)
            result = 8'd255;
    end

endmodule

// File: rtl/vga_out_csc.sv
// Colour-space output stage: RGB passthrough, YPbPr or limited-range YCbCr with
// mode-correct blanking, 3-cycle fixed latency, mode changes taken at vsync.
module vga_out_csc
    import vga_csc_pkg::*;
#(
    parameter int IN_W           = 6,
    parameter int OUT_W          = 6,
    parameter bit VS_ACTIVE_HIGH = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           mode,
    input  logic                 blank_en,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic                 csync,
    input  logic                 de,
    input  logic [3*IN_W-1:0]    din,
    output logic [3*OUT_W-1:0]   dout,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 csync_o,
    output logic                 de_o,
    output logic [1:0]           mode_active
);

    function automatic logic [7:0] expand(input logic [IN_W-1:0] c);
        logic [7:0] e;
        for (int i = 0; i < 8; i++)
            e[7-i] = c[IN_W-1-(i%IN_W)];
        return e;
    endfunction

    function automatic logic [OUT_W-1:0] trunc(input logic [7:0] v);
        return v[7 -: OUT_W];
    endfunction

    logic        vs_prev;
    logic        hist_valid;
    logic        boundary;
    mode_e       entry_mode;

    // First sample after reset only seeds the history; it is never an edge.
    assign boundary = hist_valid &&
                      (VS_ACTIVE_HIGH ? (vsync && !vs_prev) : (!vsync && vs_prev));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vs_prev     <= 1'b0;
            hist_valid  <= 1'b0;
            mode_active <= 2'd0;
        end else begin
            vs_prev    <= vsync;
            hist_valid <= 1'b1;
            if (boundary)
                mode_active <= mode;
        end
    end

    assign entry_mode = pixel_mode(mode_active);

    logic [7:0] exp_r;
    logic [7:0] exp_g;
    logic [7:0] exp_b;

    assign exp_r = expand(din[3*IN_W-1 -: IN_W]);
    assign exp_g = expand(din[2*IN_W-1 -: IN_W]);
    assign exp_b = expand(din[IN_W-1 -: IN_W]);

    coef_t      coef_y;
    coef_t      coef_cb;
    coef_t      coef_cr;
    logic [7:0] ch_y;
    logic [7:0] ch_cb;
    logic [7:0] ch_cr;

    assign coef_y  = csc_coef(entry_mode, CH_Y);
    assign coef_cb = csc_coef(entry_mode, CH_B);
    assign coef_cr = csc_coef(entry_mode, CH_R);

    vga_csc_channel u_ch_y (
        .clk(clk), .reset_n(reset_n), .r(exp_r), .g(exp_g), .b(exp_b),
        .coef(coef_y), .result(ch_y)
    );

    vga_csc_channel u_ch_cb (
        .clk(clk), .reset_n(reset_n), .r(exp_r), .g(exp_g), .b(exp_b),
        .coef(coef_cb), .result(ch_cb)
    );

    vga_csc_channel u_ch_cr (
        .clk(clk), .reset_n(reset_n), .r(exp_r), .g(exp_g), .b(exp_b),
        .coef(coef_cr), .result(ch_cr)
    );

    // Per-pixel side data travelling alongside the matrix stages.
    logic [23:0] rgb_s1;
    logic [23:0] rgb_s2;
    mode_e       mode_s1;
    mode_e       mode_s2;
    logic        blank_s1;
    logic        blank_s2;
    logic [3:0]  tim_q [LATENCY];

    // NOTE: every pipeline stage, including the timing delay array, is cleared
    // by reset so a mid-frame reset cannot release stale pixels afterwards.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rgb_s1   <= '0;
            rgb_s2   <= '0;
            mode_s1  <= MODE_RGB;
            mode_s2  <= MODE_RGB;
            blank_s1 <= 1'b0;
            blank_s2 <= 1'b0;
            for (int i = 0; i < LATENCY; i++)
                tim_q[i] <= '0;
        end else begin
            rgb_s1   <= {exp_r, exp_g, exp_b};
            rgb_s2   <= rgb_s1;
            mode_s1  <= entry_mode;
            mode_s2  <= mode_s1;
            blank_s1 <= blank_en;
            blank_s2 <= blank_s1;
            tim_q[0] <= {hsync, vsync, csync, de};
            for (int i = 1; i < LATENCY; i++)
                tim_q[i] <= tim_q[i-1];
        end
    end

    logic                 de_s2;
    logic [3*OUT_W-1:0]   dout_next;

    assign de_s2 = tim_q[1][0];

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        dout_next = '0;
        if (blank_s2 && !de_s2)
            dout_next = {trunc(blank_level(mode_s2, CH_R)),
                         trunc(blank_level(mode_s2, CH_Y)),
                         trunc(blank_level(mode_s2, CH_B))};
        else if (mode_s2 == MODE_RGB)
            dout_next = {trunc(rgb_s2[23:16]), trunc(rgb_s2[15:8]), trunc(rgb_s2[7:0])};
        else
            dout_next = {trunc(ch_cr), trunc(ch_y), trunc(ch_cb)};
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            dout <= '0;
        else
            dout <= dout_next;
    end

    assign {hsync_o, vsync_o, csync_o, de_o} = tim_q[LATENCY-1];

endmodule
